state_sequencer: RTL

STATE_SEQUENCER -- requirements
Module: state_sequencer

---
 rtl/cpu_defs.sv | 34 +++
 rtl/state_sequencer.sv | 86 ++++++++
 2 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared control-state encodings and opcode constants
// Used by the state sequencer and by the output-function decoder that
// consumes its state output. No ports.
package cpu_defs;

  // Control states. All eight 3-bit codes are assigned.
  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_AEXE = 3'b110;
  localparam logic [2:0] S_BEXE = 3'b101;
  localparam logic [2:0] S_CEXE = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_AWB  = 3'b111;
  localparam logic [2:0] S_CWB  = 3'b100;

  // Opcodes (IR[31:26]).
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // True for every opcode the machine implements.
  function automatic logic op_known(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_SW, OP_LW, OP_BEQ, OP_J, OP_HALT: op_known = 1'b1;
      default:                                                     op_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/state_sequencer.sv
// rtl/state_sequencer.sv - multicycle CPU control state sequencer
// Ports:
//   CLK        in   clock, all state updates on rising edge
//   Reset      in   asynchronous active-high reset
//   opcode     in   IR[31:26], sampled only in ID and MEM
//   state      out  registered control state
//   halted     out  sticky, set when a halt leaves ID
//   illegal    out  sticky, set when an undefined opcode leaves ID
//   retire     out  combinational pulse in the last cycle of an instruction
//   cycle_cnt  out  cycles since reset while not halted
//   instr_cnt  out  retired instructions since reset
module state_sequencer
  import cpu_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0] next_state;

  always_comb begin
    next_state = S_IF;
    case (state)
      S_IF:   next_state = halted ? S_IF : S_ID;
      S_ID: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_OR: next_state = S_AEXE;
          OP_BEQ:                next_state = S_BEXE;
          OP_SW, OP_LW:          next_state = S_CEXE;
          default:               next_state = S_IF;   // j, halt, undefined
        endcase
      end
      S_AEXE: next_state = S_AWB;
      S_AWB:  next_state = S_IF;
      S_BEXE: next_state = S_IF;
      S_CEXE: next_state = S_MEM;
      S_MEM:  next_state = (opcode == OP_LW) ? S_CWB : S_IF;
      S_CWB:  next_state = S_IF;
      default: next_state = S_IF;
    endcase
  end

  // An instruction finishes in ID when it has no execute phase, and an
  // sw finishes in MEM since it has no write-back.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_ID:   retire = (opcode == OP_J) || (opcode == OP_HALT) || !op_known(opcode);
      S_BEXE: retire = 1'b1;
      S_AWB:  retire = 1'b1;
      S_CWB:  retire = 1'b1;
      S_MEM:  retire = (opcode == OP_SW);
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= S_IF;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == S_ID && opcode == OP_HALT) halted <= 1'b1;
      if (state == S_ID && !op_known(opcode)) illegal <= 1'b1;
      // Uses the pre-edge halted value, so the edge that sets halted
      // still counts; the counter freezes from the following edge.
      if (!halted) cycle_cnt <= cycle_cnt + ONE;
      if (retire)  instr_cnt <= instr_cnt + ONE;
    end
  end

endmodule
